// File: rtl/fifo_pkg.sv
`default_nettype none
// fifo_pkg: read-mode enum and wrap-aware pointer increment shared by the FIFO files.
// Rev 1.0
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_t;

   // Wraps by explicit compare so non-power-of-two depths stay contiguous.
   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      if (ptr == depth - 32'd1) begin
         return 32'd0;
      end
      return ptr + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// fifo_ram: DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read.
// Rev 1.0
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately never reset; flush and reset only move pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// sync_fifo: parametrised single-clock FIFO with standard or FWFT read, count, flags and sticky errors.
// Rev 1.0
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 4,
   parameter int FWFT         = 0,
   parameter int ALMOST_FULL  = DEPTH - 1,
   parameter int ALMOST_EMPTY = 1,
   localparam int AW          = $clog2(DEPTH),
   localparam int CW          = $clog2(DEPTH + 1)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_wrData,
   input  logic                  i_wrEnable,
   input  logic                  i_rdEnable,
   input  logic                  i_errClear,
   output logic [DATA_WIDTH-1:0] o_rdData,
   output logic                  o_rdValid,
   output logic                  o_canWrite,
   output logic                  o_canRead,
   output logic                  o_almostFull,
   output logic                  o_almostEmpty,
   output logic [CW-1:0]         o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam fifo_mode_t MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LEVEL   = CW'(ALMOST_FULL);
   localparam logic [CW-1:0] AE_LEVEL   = CW'(ALMOST_EMPTY);

   logic [AW-1:0]         wr_addr;
   logic [AW-1:0]         rd_addr;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  wr_do;
   logic                  rd_do;
   logic                  not_empty;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   assign not_empty = (count != '0);
   assign rd_acc    = i_rdEnable & not_empty;
   assign wr_acc    = i_wrEnable & ((count != FULL_COUNT) | rd_acc);
   // Flush wins over any transfer in the same cycle.
   assign wr_do     = wr_acc & ~i_flush;
   assign rd_do     = rd_acc & ~i_flush;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (i_clock),
      .wr_en   (wr_do),
      .wr_addr (wr_addr),
      .wr_data (i_wrData),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         wr_addr <= '0;
         rd_addr <= '0;
         count   <= '0;
      end else if (i_flush) begin
         wr_addr <= '0;
         rd_addr <= '0;
         count   <= '0;
      end else begin
         if (wr_do) begin
            wr_addr <= AW'(ptr_next(32'(wr_addr), unsigned'(DEPTH)));
         end
         if (rd_do) begin
            rd_addr <= AW'(ptr_next(32'(rd_addr), unsigned'(DEPTH)));
         end
         case ({wr_do, rd_do})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A refusal in the same cycle as a clear keeps the flag set.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (i_wrEnable & ~wr_acc & ~i_flush) begin
            overflow <= 1'b1;
         end else if (i_errClear) begin
            overflow <= 1'b0;
         end
         if (i_rdEnable & ~rd_acc & ~i_flush) begin
            underflow <= 1'b1;
         end else if (i_errClear) begin
            underflow <= 1'b0;
         end
      end
   end

   generate
      if (MODE == FIFO_STD) begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_q;
         logic                  rd_valid_q;

         always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_do;
               if (rd_do) begin
                  rd_data_q <= ram_rd_data;
               end
            end
         end

         assign o_rdData  = rd_data_q;
         assign o_rdValid = rd_valid_q;
      end else begin : g_fwft
         // Head word is masked while empty so reset presents zero, not stale storage.
         assign o_rdData  = not_empty ? ram_rd_data : '0;
         assign o_rdValid = not_empty;
      end
   endgenerate

   assign o_canWrite    = (count != FULL_COUNT);
   assign o_canRead     = not_empty;
   assign o_almostFull  = (count >= AF_LEVEL);
   assign o_almostEmpty = (count <= AE_LEVEL);
   assign o_count       = count;
   assign o_overflow    = overflow;
   assign o_underflow   = underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// tb_sync_fifo: scoreboard bench for sync_fifo, standard and FWFT instances at DEPTH=5.
// Rev 1.0
module tb_sync_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic       s_fl, s_we, s_re, s_ec;
   logic [7:0] s_wd, s_rd;
   logic       s_rv, s_cw, s_cr, s_af, s_ae, s_ov, s_un;
   logic [2:0] s_cnt;

   logic       f_fl, f_we, f_re, f_ec;
   logic [7:0] f_wd, f_rd;
   logic       f_rv, f_cw, f_cr, f_af, f_ae, f_ov, f_un;
   logic [2:0] f_cnt;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q [$];

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_std (
      .i_clock(clk), .i_reset(rst_n), .i_flush(s_fl), .i_wrData(s_wd),
      .i_wrEnable(s_we), .i_rdEnable(s_re), .i_errClear(s_ec),
      .o_rdData(s_rd), .o_rdValid(s_rv), .o_canWrite(s_cw), .o_canRead(s_cr),
      .o_almostFull(s_af), .o_almostEmpty(s_ae), .o_count(s_cnt),
      .o_overflow(s_ov), .o_underflow(s_un)
   );

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_fwft (
      .i_clock(clk), .i_reset(rst_n), .i_flush(f_fl), .i_wrData(f_wd),
      .i_wrEnable(f_we), .i_rdEnable(f_re), .i_errClear(f_ec),
      .o_rdData(f_rd), .o_rdValid(f_rv), .o_canWrite(f_cw), .o_canRead(f_cr),
      .o_almostFull(f_af), .o_almostEmpty(f_ae), .o_count(f_cnt),
      .o_overflow(f_ov), .o_underflow(f_un)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic s_step(input logic we, input logic [7:0] wd, input logic re,
                         input logic fl, input logic ec);
      s_we = we; s_wd = wd; s_re = re; s_fl = fl; s_ec = ec;
      @(posedge clk); #1;
      s_we = 1'b0; s_re = 1'b0; s_fl = 1'b0; s_ec = 1'b0;
   endtask

   task automatic f_step(input logic we, input logic [7:0] wd, input logic re);
      f_we = we; f_wd = wd; f_re = re;
      @(posedge clk); #1;
      f_we = 1'b0; f_re = 1'b0;
   endtask

   // Monitor: every standard-mode valid word must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && s_rv) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_spurious: rdValid=1 with rdData %0h, expected no valid word", s_rd);
         end else begin
            check("sb_data", 32'(s_rd), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      s_fl = 0; s_we = 0; s_re = 0; s_ec = 0; s_wd = '0;
      f_fl = 0; f_we = 0; f_re = 0; f_ec = 0; f_wd = '0;
      @(posedge clk); @(posedge clk); #1;

      check("rst_count",  32'(s_cnt), 0);
      check("rst_canw",   32'(s_cw), 1);
      check("rst_canr",   32'(s_cr), 0);
      check("rst_ae",     32'(s_ae), 1);
      check("rst_af",     32'(s_af), 0);
      check("rst_valid",  32'(s_rv), 0);
      check("rst_data",   32'(s_rd), 0);
      check("rst_ovf",    32'(s_ov), 0);
      check("rst_unf",    32'(s_un), 0);
      check("rst_f_valid", 32'(f_rv), 0);
      check("rst_f_data",  32'(f_rd), 0);
      @(negedge clk) rst_n = 1'b1;

      // Fill to full
      for (int i = 0; i < 5; i++) begin
         s_step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
         check("fill_count", 32'(s_cnt), 32'(i + 1));
         check("fill_af",    32'(s_af), 32'(i + 1 >= 4));
         check("fill_ae",    32'(s_ae), 32'(i + 1 <= 1));
         check("fill_canw",  32'(s_cw), 32'(i < 4));
      end
      s_step(1'b1, 8'h16, 1'b0, 1'b0, 1'b1);
      check("ovf_set_wins", 32'(s_ov), 1);
      check("ovf_count",    32'(s_cnt), 5);
      s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ovf_cleared",  32'(s_ov), 0);

      // Drain in order
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(8'(8'h11 + i));
         s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         check("drain_count", 32'(s_cnt), 32'(4 - i));
         check("drain_valid", 32'(s_rv), 1);
      end
      s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("unf_set",   32'(s_un), 1);
      check("unf_valid", 32'(s_rv), 0);
      check("unf_hold",  32'(s_rd), 32'h15);
      s_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("unf_cleared", 32'(s_un), 0);

      // Interleaved traffic across several pointer wraps
      s_step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
      check("wrap_count", 32'(s_cnt), 1);
      s_step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
      check("wrap_count", 32'(s_cnt), 2);
      for (int k = 2; k < 12; k++) begin
         exp_q.push_back(8'(8'h30 + k - 2));
         s_step(1'b1, 8'(8'h30 + k), 1'b1, 1'b0, 1'b0);
         check("wrap_count", 32'(s_cnt), 2);
      end
      exp_q.push_back(8'h3A);
      s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("wrap_count", 32'(s_cnt), 1);
      exp_q.push_back(8'h3B);
      s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("wrap_count", 32'(s_cnt), 0);

      // Simultaneous read and write at full, then at empty
      for (int i = 0; i < 5; i++) s_step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h41);
      s_step(1'b1, 8'h46, 1'b1, 1'b0, 1'b0);
      check("full_rw_count", 32'(s_cnt), 5);
      check("full_rw_ovf",   32'(s_ov), 0);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(8'(8'h42 + i));
         s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      check("full_rw_drained", 32'(s_cnt), 0);
      s_step(1'b1, 8'h50, 1'b1, 1'b0, 1'b0);
      check("empty_rw_unf",   32'(s_un), 1);
      check("empty_rw_count", 32'(s_cnt), 1);
      check("empty_rw_valid", 32'(s_rv), 0);
      exp_q.push_back(8'h50);
      s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      check("empty_rw_after", 32'(s_cnt), 0);

      // Flush with a simultaneous write
      for (int i = 0; i < 3; i++) s_step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0);
      check("pre_flush_count", 32'(s_cnt), 3);
      s_step(1'b1, 8'h64, 1'b0, 1'b1, 1'b0);
      check("flush_count", 32'(s_cnt), 0);
      check("flush_ovf",   32'(s_ov), 0);
      check("flush_canr",  32'(s_cr), 0);
      s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("post_flush_unf", 32'(s_un), 1);

      // Asynchronous reset between edges while a read word is presented
      s_step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
      s_step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
      s_step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("pre_arst_valid", 32'(s_rv), 1);
      check("pre_arst_data",  32'(s_rd), 32'h71);
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 32'(s_cnt), 0);
      check("arst_valid", 32'(s_rv), 0);
      check("arst_data",  32'(s_rd), 0);
      check("arst_unf",   32'(s_un), 0);
      check("arst_canr",  32'(s_cr), 0);
      check("arst_canw",  32'(s_cw), 1);
      @(negedge clk) rst_n = 1'b1;

      // FWFT instance
      f_step(1'b1, 8'hA5, 1'b0);
      check("fwft_data",  32'(f_rd), 32'hA5);
      check("fwft_valid", 32'(f_rv), 1);
      check("fwft_count", 32'(f_cnt), 1);
      f_step(1'b0, 8'h00, 1'b1);
      check("fwft_pop_count", 32'(f_cnt), 0);
      check("fwft_pop_valid", 32'(f_rv), 0);
      f_step(1'b1, 8'hB1, 1'b0);
      f_step(1'b1, 8'hB2, 1'b0);
      check("fwft_head1", 32'(f_rd), 32'hB1);
      f_step(1'b0, 8'h00, 1'b1);
      check("fwft_head2", 32'(f_rd), 32'hB2);
      check("fwft_count2", 32'(f_cnt), 1);
      f_step(1'b1, 8'hB3, 1'b1);
      check("fwft_head3", 32'(f_rd), 32'hB3);
      check("fwft_count3", 32'(f_cnt), 1);
      check("fwft_unf", 32'(f_un), 0);

      @(posedge clk); #1;
      check("sb_drain", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO that succeeds the fixed 4-entry queue in the base library. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through read mode, an exact occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and sticky overflow/underflow error flags. It sits between pipeline stages and peripherals wherever the core buffers data inside one clock domain.

## Interface
- `DATA_WIDTH`, 8: width of each entry.
- `DEPTH`, 4: number of entries; any value ≥ 2.
- `FWFT`, 0: read mode. 0 = standard (registered read); 1 = first-word-fall-through.
- `ALMOST_FULL`, DEPTH-1: `o_almostFull` asserts when count ≥ this value; legal range 1..DEPTH.
- `ALMOST_EMPTY`, 1: `o_almostEmpty` asserts when count ≤ this value; legal range 0..DEPTH-1.
- `i_clock` input 1: single clock, rising edge.
- `i_reset` input 1: reset, asynchronous and active-low.
- `i_flush` input 1: synchronous clear of contents.
- `i_wrData` input DATA_WIDTH: write data.
- `i_wrEnable` input 1: write request.
- `i_rdEnable` input 1: read/pop request.
- `i_errClear` input 1: clears the sticky error flags.
- `o_rdData` output DATA_WIDTH: read data.
- `o_rdValid` output 1: `o_rdData` carries a freshly read word (standard mode) or a valid head word (FWFT mode).
- `o_canWrite` output 1: not full.
- `o_canRead` output 1: not empty.
- `o_almostFull` output 1: count ≥ ALMOST_FULL.
- `o_almostEmpty` output 1: count ≤ ALMOST_EMPTY.
- `o_count` output $clog2(DEPTH+1): current occupancy, 0..DEPTH.
- `o_overflow` output 1: sticky; a write was refused.
- `o_underflow` output 1: sticky; a read was refused.

## Operation
- Read accept: `rdAcc` = `i_rdEnable` & (count ≠ 0).
- Write accept: `wrAcc` = `i_wrEnable` & ((count ≠ DEPTH) | `rdAcc`).
  - When full, a write together with an accepted read succeeds.
  - When empty, a read together with a write is refused. The write is still accepted.
- Pointers `wrAddr` and `rdAddr` are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 by explicit compare, never by modulo-2^n.
- Count update:
  - +1 on `wrAcc` only.
  - −1 on `rdAcc` only.
  - Unchanged when both or neither are accepted.
  - Count never exceeds DEPTH and never underflows.
- Standard mode:
  - On `rdAcc`, `o_rdData` ← entry[rdAddr] and `o_rdValid` is 1 the next cycle; otherwise `o_rdValid` is 0.
  - `o_rdData` holds its last value until the next accepted read.
- FWFT mode:
  - `o_rdData` = entry[rdAddr] combinationally from the storage.
  - `o_rdValid` = `o_canRead`.
  - `i_rdEnable` acts as a pop.
- Flush: `i_flush` high at a clock edge sets pointers and count to 0 and clears `o_rdValid`.
  - It takes priority over any simultaneous read or write, which are discarded without error.
  - Storage contents are not cleared.
- Errors:
  - `i_wrEnable` & !`wrAcc` sets `o_overflow`.
  - `i_rdEnable` & !`rdAcc` sets `o_underflow`.
  - `i_errClear` clears both; a set in the same cycle as a clear wins.
  - Flush does not clear the error flags.
- Reset (asynchronous, `i_reset` = 0):
  - Pointers and count = 0.
  - `o_rdData` = 0, `o_rdValid` = 0, `o_overflow` = 0, `o_underflow` = 0.
  - Derived outputs at reset: `o_canWrite` = 1, `o_canRead` = 0, `o_almostEmpty` = 1, `o_almostFull` = 0 (given ALMOST_FULL ≥ 1).
  - Reset deasserting mid-transfer leaves no partial state.

## Timing
- All status outputs are derived from registered count; they update in the cycle after the accepting edge.
- Write-to-read latency is 1 cycle. A word written at edge N is:
  - visible on `o_rdData` in FWFT mode, or
  - poppable in either mode,
  - from edge N onward, i.e. in the cycle that follows it.
- Standard-mode read latency is 1 cycle: `i_rdEnable` sampled at edge N gives data and `o_rdValid` after edge N.
- Sustained throughput is one write and one read per cycle, including at full and at empty+write.
- No combinational path from `i_wrEnable`/`i_wrData` to any output.
- FWFT `o_rdData` depends combinationally only on registered state.

## Structure
- `fifo_pkg`: the `fifo_mode_t` enum (`FIFO_STD`, `FIFO_FWFT`) and the pointer-increment-with-wrap function.
- Sub-module `fifo_ram`: DEPTH × DATA_WIDTH register array with one synchronous write port and one asynchronous read port.
- `sync_fifo` contains the pointer logic, count, flags and read-mode logic.

## Test plan
All scenarios use DATA_WIDTH=8 and DEPTH=5.

1. Reset, then write 0x11..0x15 (standard mode).
   - `o_count` steps 1..5; `o_almostFull` rises at count 4; `o_canWrite` = 0 after the 5th write.
   - A 6th write sets `o_overflow`; count stays 5.
2. From full, read 5 times.
   - `o_rdData` = 0x11..0x15 in order, each with `o_rdValid` one cycle after its request.
   - A 6th read sets `o_underflow`; `o_rdData` holds 0x15.
3. Wrap-around: run 12 writes interleaved with 12 reads.
   - Data order is preserved across the pointer wrap at index 4 → 0.
   - Count never exceeds 2.
4. Simultaneous read and write.
   - At full: both accepted, count stays 5, no overflow.
   - At empty: write accepted, read refused, `o_underflow` = 1, count = 1.
5. FWFT=1: write 0xA5 at edge N.
   - `o_rdData` = 0xA5 and `o_rdValid` = 1 after edge N with no read issued.
   - A pop at edge N+1 returns count to 0.
6. Flush and asynchronous reset.
   - With 3 entries, `i_flush` plus a simultaneous write gives count 0 and no overflow.
   - Asserting `i_reset` low between clock edges clears all registered outputs immediately.
